// File: rtl/sysarr_pkg.sv
// Shared parameters, FSM state type and operand type for the systolic-array feed sequencer.
package sysarr_pkg;

   localparam int unsigned N          = 8;
   localparam int unsigned DATA_WIDTH = 16;
   localparam int unsigned MAX_K      = 256;
   localparam int unsigned KW         = $clog2(MAX_K + 1);
   localparam int unsigned PE_LAT     = 1;
   localparam int unsigned DRAIN_CYC  = 2 * (N - 1) + PE_LAT + 1;

   localparam logic [KW-1:0] MAX_K_KW = KW'(MAX_K);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      DONE
   } sysctrl_state_e;

   typedef logic signed [DATA_WIDTH-1:0] operand_t;

   function automatic logic [KW-1:0] sat_k(input logic [KW-1:0] k);
      return (k > MAX_K_KW) ? MAX_K_KW : k;
   endfunction

endpackage

// File: rtl/systolic_feed_ctrl_skew_line.sv
// Fixed-depth delay line with a per-stage valid bit; output is zero whenever the emerging stage is invalid.
module skew_line #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned W     = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         vld_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] data_o
);

   if (DEPTH == 0) begin : g_wire
      assign data_o = vld_i ? data_i : '0;
   end else begin : g_pipe
      logic         vld_q  [DEPTH];
      logic [W-1:0] data_q [DEPTH];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
               vld_q[s]  <= 1'b0;
               data_q[s] <= '0;
            end
         end else begin
            vld_q[0]  <= vld_i;
            data_q[0] <= data_i;
            for (int unsigned s = 1; s < DEPTH; s++) begin
               vld_q[s]  <= vld_q[s-1];
               data_q[s] <= data_q[s-1];
            end
         end
      end

      assign data_o = vld_q[DEPTH-1] ? data_q[DEPTH-1] : '0;
   end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Feed sequencer for the NxN output-stationary systolic array: clear, skewed A/B feed, drain, done.
// Optional busy-cycle counter on port perf_cycles when SYSCTRL_PERF_CNT_EN is defined.
module systolic_feed_ctrl
   import sysarr_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [KW-1:0]           k_len,
   output logic                    busy,
   output logic                    done,
   output logic                    a_rd_en,
   output logic [KW-2:0]           a_rd_addr,
   input  logic [N*DATA_WIDTH-1:0] a_rd_data,
   output logic                    b_rd_en,
   output logic [KW-2:0]           b_rd_addr,
   input  logic [N*DATA_WIDTH-1:0] b_rd_data,
   output logic [N*DATA_WIDTH-1:0] a_feed,
   output logic [N*DATA_WIDTH-1:0] b_feed,
   output logic                    arr_rst_n
`ifdef SYSCTRL_PERF_CNT_EN
   ,
   output logic [31:0]             perf_cycles
`endif
);

   localparam int unsigned DRW = $clog2(DRAIN_CYC);
   localparam int unsigned OW  = $bits(operand_t);

   sysctrl_state_e state_q;
   logic [KW-1:0]  k_len_q;
   logic [KW-1:0]  k_cnt_q;
   logic [DRW-1:0] drain_q;
   logic           busy_q;
   logic           done_q;
   logic           rd_en_q;
   logic [KW-2:0]  addr_q;
   logic           arr_rst_n_q;
   logic           rd_vld_q;

   // k_cnt_q counts reads already presented, so the last address is on the bus when it equals k_len_q
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_len_q     <= '0;
         k_cnt_q     <= '0;
         drain_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         addr_q      <= '0;
         arr_rst_n_q <= 1'b0;
         rd_vld_q    <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         rd_en_q  <= 1'b0;
         rd_vld_q <= rd_en_q;
         unique case (state_q)
            IDLE, DONE: begin
               state_q     <= IDLE;
               busy_q      <= 1'b0;
               arr_rst_n_q <= 1'b1;
               if (start) begin
                  state_q     <= CLEAR;
                  k_len_q     <= sat_k(k_len);
                  busy_q      <= 1'b1;
                  arr_rst_n_q <= 1'b0;
               end
            end
            CLEAR: begin
               arr_rst_n_q <= 1'b1;
               if (k_len_q == '0) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= FEED;
                  rd_en_q <= 1'b1;
                  addr_q  <= '0;
                  k_cnt_q <= KW'(1);
               end
            end
            FEED: begin
               if (k_cnt_q == k_len_q) begin
                  state_q <= DRAIN;
                  drain_q <= '0;
               end else begin
                  rd_en_q <= 1'b1;
                  addr_q  <= k_cnt_q[KW-2:0];
                  k_cnt_q <= k_cnt_q + 1'b1;
               end
            end
            DRAIN: begin
               if (drain_q == DRW'(DRAIN_CYC - 1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  drain_q <= drain_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      skew_line #(
         .DEPTH(i),
         .W    (OW)
      ) u_skew_a (
         .clk_i (clk),
         .rst_ni(rst_n),
         .vld_i (rd_vld_q),
         .data_i(a_rd_data[i*OW +: OW]),
         .data_o(a_feed[i*OW +: OW])
      );

      skew_line #(
         .DEPTH(i),
         .W    (OW)
      ) u_skew_b (
         .clk_i (clk),
         .rst_ni(rst_n),
         .vld_i (rd_vld_q),
         .data_i(b_rd_data[i*OW +: OW]),
         .data_o(b_feed[i*OW +: OW])
      );
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign a_rd_en   = rd_en_q;
   assign b_rd_en   = rd_en_q;
   assign a_rd_addr = addr_q;
   assign b_rd_addr = addr_q;
   assign arr_rst_n = arr_rst_n_q;

`ifdef SYSCTRL_PERF_CNT_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_q <= '0;
      end else if (busy_q && (perf_q != '1)) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Randomized self-checking bench for systolic_feed_ctrl against a cycle-timeline reference model.
module tb_systolic_feed_ctrl;
   import sysarr_pkg::*;

   localparam int unsigned LW = N * DATA_WIDTH;
   localparam int          NC = 4096;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [KW-1:0]   k_len;
   logic            busy;
   logic            done;
   logic            a_rd_en;
   logic [KW-2:0]   a_rd_addr;
   logic [LW-1:0]   a_rd_data;
   logic            b_rd_en;
   logic [KW-2:0]   b_rd_addr;
   logic [LW-1:0]   b_rd_data;
   logic [LW-1:0]   a_feed;
   logic [LW-1:0]   b_feed;
   logic            arr_rst_n;
`ifdef SYSCTRL_PERF_CNT_EN
   logic [31:0]     perf_cycles;
   longint          perf_m;
`endif

   always #5 clk = ~clk;

   systolic_feed_ctrl u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .k_len      (k_len),
      .busy       (busy),
      .done       (done),
      .a_rd_en    (a_rd_en),
      .a_rd_addr  (a_rd_addr),
      .a_rd_data  (a_rd_data),
      .b_rd_en    (b_rd_en),
      .b_rd_addr  (b_rd_addr),
      .b_rd_data  (b_rd_data),
      .a_feed     (a_feed),
      .b_feed     (b_feed),
      .arr_rst_n  (arr_rst_n)
`ifdef SYSCTRL_PERF_CNT_EN
      ,
      .perf_cycles(perf_cycles)
`endif
   );

   // Tile buffers: 1-cycle read latency, garbage on the bus when not read.
   logic [LW-1:0] mem_a [256];
   logic [LW-1:0] mem_b [256];

   always @(posedge clk) begin
      a_rd_data <= a_rd_en ? mem_a[a_rd_addr] : LW'({$urandom, $urandom, $urandom, $urandom});
      b_rd_data <= b_rd_en ? mem_b[b_rd_addr] : LW'({$urandom, $urandom, $urandom, $urandom});
   end

   // Expected behaviour per absolute cycle, filled in when an operation is accepted.
   bit            exp_busy [NC];
   bit            exp_done [NC];
   bit            exp_rd   [NC];
   bit            exp_arst [NC];
   int            exp_addr [NC];
   logic [LW-1:0] exp_a    [NC];
   logic [LW-1:0] exp_b    [NC];
   logic [LW-1:0] obs_a    [NC];
   logic [LW-1:0] obs_b    [NC];

   int cyc   = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int cur_s = 0;
   int cur_k = 0;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic longint lane(input logic [LW-1:0] v, input int i);
      operand_t x;
      x = v[i*DATA_WIDTH +: DATA_WIDTH];
      return longint'(x);
   endfunction

   task automatic clear_future(input int from);
      for (int c = from; c < NC; c++) begin
         exp_busy[c] = 1'b0;
         exp_done[c] = 1'b0;
         exp_rd[c]   = 1'b0;
         exp_arst[c] = 1'b1;
         exp_addr[c] = 0;
         exp_a[c]    = '0;
         exp_b[c]    = '0;
      end
   endtask

   task automatic schedule(input int s, input int kin, input bit ident);
      int kk;
      kk = (kin > int'(MAX_K)) ? int'(MAX_K) : kin;
      for (int k = 0; k < kk; k++) begin
         if (ident) begin
            for (int i = 0; i < int'(N); i++) begin
               mem_a[k][i*DATA_WIDTH +: DATA_WIDTH] = (i == k) ? DATA_WIDTH'(1) : '0;
               mem_b[k][i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(8 * k + i);
            end
         end else begin
            mem_a[k] = LW'({$urandom, $urandom, $urandom, $urandom});
            mem_b[k] = LW'({$urandom, $urandom, $urandom, $urandom});
         end
      end
      exp_arst[s+1] = 1'b0;
      if (kk == 0) begin
         exp_busy[s+1] = 1'b1;
         exp_done[s+2] = 1'b1;
      end else begin
         for (int r = 1; r <= kk + 17; r++) exp_busy[s+r] = 1'b1;
         for (int k = 0; k < kk; k++) begin
            exp_rd[s+2+k]   = 1'b1;
            exp_addr[s+2+k] = k;
            for (int i = 0; i < int'(N); i++) begin
               exp_a[s+3+k+i][i*DATA_WIDTH +: DATA_WIDTH] = mem_a[k][i*DATA_WIDTH +: DATA_WIDTH];
               exp_b[s+3+k+i][i*DATA_WIDTH +: DATA_WIDTH] = mem_b[k][i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         exp_done[s+kk+18] = 1'b1;
      end
      cur_s = s;
      cur_k = kk;
   endtask

   // Run the observed feeds through an ideal output-stationary array and compare with A*B.
   task automatic check_c();
      for (int i = 0; i < int'(N); i++) begin
         for (int j = 0; j < int'(N); j++) begin
            longint acc;
            longint ref_v;
            acc   = 0;
            ref_v = 0;
            for (int c = cur_s + 1; c <= cyc; c++) begin
               if (c - j >= 0 && c - i >= 0)
                  acc += lane(obs_a[c-j], i) * lane(obs_b[c-i], j);
            end
            for (int k = 0; k < cur_k; k++)
               ref_v += lane(mem_a[k], i) * lane(mem_b[k], j);
            chk($sformatf("C[%0d][%0d]", i, j), LW'(acc), LW'(ref_v));
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      obs_a[cyc] = a_feed;
      obs_b[cyc] = b_feed;
      if (!rst_n) begin
`ifdef SYSCTRL_PERF_CNT_EN
         perf_m = 0;
`endif
         chk("rst_busy", LW'(busy), '0);
         chk("rst_done", LW'(done), '0);
         chk("rst_arr_rst_n", LW'(arr_rst_n), '0);
         chk("rst_a_rd_en", LW'(a_rd_en), '0);
         chk("rst_b_rd_en", LW'(b_rd_en), '0);
         chk("rst_a_rd_addr", LW'(a_rd_addr), '0);
         chk("rst_b_rd_addr", LW'(b_rd_addr), '0);
         chk("rst_a_feed", a_feed, '0);
         chk("rst_b_feed", b_feed, '0);
      end else begin
         chk("busy", LW'(busy), LW'(exp_busy[cyc]));
         chk("done", LW'(done), LW'(exp_done[cyc]));
         chk("arr_rst_n", LW'(arr_rst_n), LW'(exp_arst[cyc]));
         chk("a_rd_en", LW'(a_rd_en), LW'(exp_rd[cyc]));
         chk("b_rd_en", LW'(b_rd_en), LW'(exp_rd[cyc]));
         if (exp_rd[cyc]) begin
            chk("a_rd_addr", LW'(a_rd_addr), LW'(exp_addr[cyc]));
            chk("b_rd_addr", LW'(b_rd_addr), LW'(exp_addr[cyc]));
         end
         chk("a_feed", a_feed, exp_a[cyc]);
         chk("b_feed", b_feed, exp_b[cyc]);
         if (exp_done[cyc]) check_c();
      end
`ifdef SYSCTRL_PERF_CNT_EN
      chk("perf_cycles", LW'(perf_cycles), LW'(perf_m));
      if (rst_n && exp_busy[cyc]) perf_m++;
`endif
   endtask

   task automatic drive_start(input int kin, input bit ident);
      start = 1'b1;
      k_len = KW'(kin);
      if (rst_n && !exp_busy[cyc]) schedule(cyc, kin, ident);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      k_len = '0;
`ifdef SYSCTRL_PERF_CNT_EN
      perf_m = 0;
`endif
      for (int k = 0; k < 256; k++) begin
         mem_a[k] = '0;
         mem_b[k] = '0;
      end
      clear_future(0);

      repeat (3) step();
      rst_n = 1'b1;
      repeat (3) step();

      // A = identity, B[k][j] = 8k+j, K = 8
      drive_start(8, 1'b1);
      step();
      start = 1'b0;
      repeat (30) step();

      // K = 0: clear then done, no reads
      drive_start(0, 1'b0);
      step();
      start = 1'b0;
      repeat (5) step();

      // start pulse during FEED is ignored
      drive_start(10, 1'b0);
      step();
      start = 1'b0;
      repeat (4) step();
      drive_start(7, 1'b0);
      step();
      start = 1'b0;
      repeat (30) step();

      // start held high across DONE gives back-to-back operations
      drive_start(5, 1'b0);
      step();
      for (int n = 0; n < 60; n++) begin
         drive_start(6, 1'b0);
         step();
      end
      start = 1'b0;
      repeat (30) step();

      // reset in FEED aborts the operation at once
      drive_start(12, 1'b0);
      step();
      start = 1'b0;
      repeat (4) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_a_rd_en", LW'(a_rd_en), '0);
      chk("abort_b_rd_en", LW'(b_rd_en), '0);
      chk("abort_a_feed", a_feed, '0);
      chk("abort_b_feed", b_feed, '0);
      chk("abort_arr_rst_n", LW'(arr_rst_n), '0);
      chk("abort_busy", LW'(busy), '0);
      clear_future(cyc + 1);
`ifdef SYSCTRL_PERF_CNT_EN
      perf_m = 0;
`endif
      repeat (2) step();
      rst_n = 1'b1;
      repeat (40) step();

      // k_len above MAX_K saturates
      drive_start(300, 1'b0);
      step();
      start = 1'b0;
      repeat (280) step();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            drive_start(int'($urandom_range(0, 20)), 1'b0);
         end else begin
            start = 1'b0;
            k_len = KW'($urandom);
         end
         step();
      end
      start = 1'b0;
      repeat (40) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
